// File: rtl/fpu_add_result_merge.sv
// Adder result merge stage: pairs in-order exception decisions with core results behind a valid/ready port.
// Optional FPU_ADD_MERGE_STATS_EN adds a saturating exc_count of exception results popped at the output.
module fpu_add_result_merge #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic                  exc_sel,
   input  logic [DATA_WIDTH-1:0] exc_out,
   input  logic                  core_valid,
   input  logic [DATA_WIDTH-1:0] core_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_exc,
   output logic                  out_inf,
`ifdef FPU_ADD_MERGE_STATS_EN
   output logic [15:0]           exc_count,
`endif
   output logic                  err_orphan
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CAP = CW'(DEPTH);

   logic                  dec_sel_mem [DEPTH];
   logic [DATA_WIDTH-1:0] dec_val_mem [DEPTH];
   logic                  res_exc_mem [DEPTH];
   logic [DATA_WIDTH-1:0] res_dat_mem [DEPTH];

   logic [AW-1:0] dec_wr, dec_rd, res_wr, res_rd;
   logic [CW-1:0] dec_cnt, res_cnt, in_flight;

   logic issue_fire, pair_fire, pop_fire, orphan;

   assign issue_ready = ~rst & (in_flight < CAP);
   assign issue_fire  = issue_valid & issue_ready;
   assign pair_fire   = core_valid & (dec_cnt != '0);
   assign orphan      = core_valid & (dec_cnt == '0);
   assign out_valid   = (res_cnt != '0);
   assign pop_fire    = out_valid & out_ready;

   // Head entry is held in flops; gated to zero while empty so idle/reset output reads 0.
   assign out_data = out_valid ? res_dat_mem[res_rd] : '0;
   assign out_exc  = out_valid & res_exc_mem[res_rd];
   assign out_inf  = (&out_data[DATA_WIDTH-2:DATA_WIDTH-9]) & ~(|out_data[DATA_WIDTH-10:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_wr     <= '0;
         dec_rd     <= '0;
         res_wr     <= '0;
         res_rd     <= '0;
         dec_cnt    <= '0;
         res_cnt    <= '0;
         in_flight  <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (issue_fire) begin
            dec_sel_mem[dec_wr] <= exc_sel;
            dec_val_mem[dec_wr] <= exc_out;
            dec_wr              <= dec_wr + AW'(1);
         end
         if (pair_fire) begin
            res_exc_mem[res_wr] <= ~dec_sel_mem[dec_rd];
            res_dat_mem[res_wr] <= dec_sel_mem[dec_rd] ? core_result : dec_val_mem[dec_rd];
            res_wr              <= res_wr + AW'(1);
            dec_rd              <= dec_rd + AW'(1);
         end
         if (pop_fire)
            res_rd <= res_rd + AW'(1);

         case ({issue_fire, pair_fire})
            2'b10:   dec_cnt <= dec_cnt + CW'(1);
            2'b01:   dec_cnt <= dec_cnt - CW'(1);
            default: dec_cnt <= dec_cnt;
         endcase
         case ({pair_fire, pop_fire})
            2'b10:   res_cnt <= res_cnt + CW'(1);
            2'b01:   res_cnt <= res_cnt - CW'(1);
            default: res_cnt <= res_cnt;
         endcase
         case ({issue_fire, pop_fire})
            2'b10:   in_flight <= in_flight + CW'(1);
            2'b01:   in_flight <= in_flight - CW'(1);
            default: in_flight <= in_flight;
         endcase

         if (orphan)
            err_orphan <= 1'b1;
      end
   end

`ifdef FPU_ADD_MERGE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)
         exc_count <= '0;
      else if (pop_fire && out_exc && exc_count != 16'hFFFF)
         exc_count <= exc_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fpu_add_result_merge.sv
// Randomized bench for fpu_add_result_merge against a queue-based reference model.
// Covers exc_count when built with FPU_ADD_MERGE_STATS_EN.
module tb_fpu_add_result_merge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic        exc_sel = 1'b0;
   logic [31:0] exc_out = '0;
   logic        core_valid = 1'b0;
   logic [31:0] core_result = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_exc;
   logic        out_inf;
   logic        err_orphan;
`ifdef FPU_ADD_MERGE_STATS_EN
   logic [15:0] exc_count;
   int          m_exc_cnt = 0;
`endif

   always #5 clk = ~clk;

   fpu_add_result_merge #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .exc_sel     (exc_sel),
      .exc_out     (exc_out),
      .core_valid  (core_valid),
      .core_result (core_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_exc     (out_exc),
      .out_inf     (out_inf),
`ifdef FPU_ADD_MERGE_STATS_EN
      .exc_count   (exc_count),
`endif
      .err_orphan  (err_orphan)
   );

   // Reference model: pending decisions, merged results awaiting output, in-flight op count.
   bit          dq_sel [$];
   logic [31:0] dq_val [$];
   logic [32:0] rq     [$];
   int          m_inflight = 0;
   bit          m_err = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic bit is_inf(input logic [31:0] d);
      return d[30:0] == 31'h7F80_0000;
   endfunction

   task automatic check_outputs();
      chk("issue_ready", issue_ready, (!rst && m_inflight < 4));
      chk("out_valid", out_valid, rq.size() > 0);
      chk("err_orphan", err_orphan, m_err);
      if (rq.size() > 0) begin
         chk("out_data", out_data, rq[0][31:0]);
         chk("out_exc", out_exc, rq[0][32]);
         chk("out_inf", out_inf, is_inf(rq[0][31:0]));
      end
`ifdef FPU_ADD_MERGE_STATS_EN
      chk("exc_count", exc_count, m_exc_cnt);
`endif
   endtask

   // One clock: check state from the previous edge, drive new inputs, advance the model.
   task automatic step(input bit rs, input bit iv, input bit sel, input logic [31:0] eo,
                       input bit cv, input logic [31:0] cr, input bit ordy);
      bit ready, fire, pop;
      @(negedge clk);
      check_outputs();
      rst = rs; issue_valid = iv; exc_sel = sel; exc_out = eo;
      core_valid = cv; core_result = cr; out_ready = ordy;
      if (rs) begin
         dq_sel.delete(); dq_val.delete(); rq.delete();
         m_inflight = 0; m_err = 1'b0;
`ifdef FPU_ADD_MERGE_STATS_EN
         m_exc_cnt = 0;
`endif
      end else begin
         ready = m_inflight < 4;
         fire  = iv && ready;
         pop   = ordy && rq.size() > 0;
         if (pop) begin
`ifdef FPU_ADD_MERGE_STATS_EN
            if (rq[0][32] && m_exc_cnt < 65535) m_exc_cnt++;
`endif
            void'(rq.pop_front());
         end
         if (cv) begin
            if (dq_sel.size() == 0) m_err = 1'b1;
            else begin
               bit s;
               logic [31:0] v;
               s = dq_sel.pop_front();
               v = dq_val.pop_front();
               rq.push_back(s ? {1'b0, cr} : {1'b1, v});
            end
         end
         if (fire) begin
            dq_sel.push_back(sel);
            dq_val.push_back(eo);
         end
         m_inflight += int'(fire) - int'(pop);
      end
   endtask

   task automatic idle(input bit ordy);
      step(0, 0, 0, '0, 0, '0, ordy);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      step(1, 0, 0, '0, 0, '0, 0);

      // normal path
      step(0, 1, 1, 32'h0, 0, '0, 1);
      idle(1); idle(1); idle(1);
      step(0, 0, 0, '0, 1, 32'h4040_0000, 1);
      @(posedge clk); #1;
      chk("normal_valid", out_valid, 1);
      chk("normal_data", out_data, 32'h4040_0000);
      chk("normal_exc", out_exc, 0);
      chk("normal_inf", out_inf, 0);

      // exception override
      step(0, 1, 0, 32'h7F80_0000, 0, '0, 1);
      step(0, 0, 0, '0, 1, 32'h1234_5678, 1);
      @(posedge clk); #1;
      chk("exc_data", out_data, 32'h7F80_0000);
      chk("exc_flag", out_exc, 1);
      chk("exc_inf", out_inf, 1);
      idle(1); idle(1);

      // backpressure to full, then drain
      for (int i = 0; i < 4; i++) step(0, 1, i[0], 32'hFF80_0000, 0, '0, 0);
      @(posedge clk); #1;
      chk("full_ready", issue_ready, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, '0, 1, 32'h3F80_0000 + i, 0);
      idle(0); idle(0);
      for (int i = 0; i < 6; i++) idle(1);

      // orphan
      step(0, 0, 0, '0, 1, 32'hDEAD_BEEF, 1);
      @(posedge clk); #1;
      chk("orphan_err", err_orphan, 1);
      chk("orphan_novalid", out_valid, 0);

      // reset mid-stream with two ops in flight, then a stale core result
      step(0, 1, 1, '0, 0, '0, 0);
      step(0, 1, 0, 32'h1, 0, '0, 0);
      step(1, 0, 0, '0, 0, '0, 0);
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_exc", out_exc, 0);
      chk("rst_inf", out_inf, 0);
      chk("rst_err", err_orphan, 0);
      step(0, 0, 0, '0, 1, 32'h5, 0);
      @(posedge clk); #1;
      chk("stale_orphan", err_orphan, 1);
      step(1, 0, 0, '0, 0, '0, 0);

      // random traffic with simultaneous issue / pair / pop
      for (int i = 0; i < 400; i++) begin
         logic [31:0] eo;
         eo = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 1, 31'h7F80_0000} : $urandom;
         step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, eo,
              dq_sel.size() > 0 && $urandom_range(0, 2) != 0, $urandom,
              $urandom_range(0, 3) != 0);
      end

      for (int i = 0; i < 100 && (rq.size() > 0 || dq_sel.size() > 0); i++)
         step(0, 0, 0, '0, dq_sel.size() > 0, $urandom, 1);
      chk("drain_done", rq.size() + dq_sel.size(), 0);
      idle(1);
      @(negedge clk);
      check_outputs();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
